// File: rtl/multdiv_issue_scheduler_pkg.sv
// multdiv_issue_scheduler_pkg: shared encodings for the mul/div issue scheduler.
// FSM state and operation codes used by the top and the bench.
package multdiv_issue_scheduler_pkg;

  typedef enum logic [1:0] {
    MDS_IDLE  = 2'd0,
    MDS_START = 2'd1,
    MDS_WAIT  = 2'd2,
    MDS_WB    = 2'd3
  } mds_state_e;

  localparam logic MD_OP_MULT = 1'b0;
  localparam logic MD_OP_DIV  = 1'b1;

endpackage

// File: rtl/multdiv_issue_scheduler_watchdog.sv
// md_watchdog: counts cycles spent waiting on the mul/div unit.
// Only instantiated when MD_WATCHDOG_EN is defined.
module md_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  // cycle counter, cleared on entry to the wait and frozen once expired
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable & (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_issue_scheduler.sv
// multdiv_issue_scheduler: shares one iterative mul/div unit across two lanes.
// Optional result-wait watchdog is enabled by defining MD_WATCHDOG_EN.
module multdiv_issue_scheduler #(
  parameter int DATA_W = 32,
  parameter int RD_W = 5
`ifdef MD_WATCHDOG_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_top,
  input  logic              op_top,
  input  logic [DATA_W-1:0] a_top,
  input  logic [DATA_W-1:0] b_top,
  input  logic [RD_W-1:0]   rd_top,
  input  logic              req_bot,
  input  logic              op_bot,
  input  logic [DATA_W-1:0] a_bot,
  input  logic [DATA_W-1:0] b_bot,
  input  logic [RD_W-1:0]   rd_bot,
  input  logic              flush,
  output logic              grant_top,
  output logic              grant_bot,
  output logic              md_ctrl_mult,
  output logic              md_ctrl_div,
  output logic [DATA_W-1:0] md_operandA,
  output logic [DATA_W-1:0] md_operandB,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  input  logic              md_resultRDY,
  output logic              wb_valid,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_exception,
  output logic              busy,
  output logic [RD_W-1:0]   busy_rd
);
  import multdiv_issue_scheduler_pkg::*;

  mds_state_e        state;
  mds_state_e        state_nxt;
  logic              rst_q;
  logic              live;
  logic              idle;
  logic              hold;
  logic              wd_expired;
  logic              op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [RD_W-1:0]   rd_q;
  logic [DATA_W-1:0] res_q;
  logic              exc_q;

`ifdef MD_WATCHDOG_EN
  md_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (state == MDS_START),
    .enable (state == MDS_WAIT),
    .expired(wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  // outputs stay quiet during reset and the cycle after it
  assign live = ~reset & ~rst_q;
  assign idle = (state == MDS_IDLE);
  assign hold = live & ((state == MDS_START) | (state == MDS_WAIT));

  assign grant_top = live & idle & ~flush & req_top;
  assign grant_bot = live & idle & ~flush & req_bot & ~req_top;

  assign md_ctrl_mult = live & (state == MDS_START) & (op_q == MD_OP_MULT);
  assign md_ctrl_div  = live & (state == MDS_START) & (op_q == MD_OP_DIV);
  assign md_operandA  = hold ? a_q : '0;
  assign md_operandB  = hold ? b_q : '0;

  assign wb_valid     = live & (state == MDS_WB);
  assign wb_rd        = wb_valid ? rd_q : '0;
  assign wb_data      = wb_valid ? res_q : '0;
  assign wb_exception = wb_valid & exc_q;

  assign busy    = live & ~idle;
  assign busy_rd = busy ? rd_q : '0;

  // next-state: flush aborts before writeback, never during it
  always_comb begin
    state_nxt = state;
    unique case (state)
      MDS_IDLE:  if (grant_top | grant_bot) state_nxt = MDS_START;
      MDS_START: state_nxt = flush ? MDS_IDLE : MDS_WAIT;
      MDS_WAIT: begin
        if (flush) state_nxt = MDS_IDLE;
        else if (md_resultRDY | wd_expired) state_nxt = MDS_WB;
      end
      MDS_WB:    state_nxt = MDS_IDLE;
      default:   state_nxt = MDS_IDLE;
    endcase
  end

  // state, holding registers and captured result
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= MDS_IDLE;
      rst_q <= 1'b1;
      op_q  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      rd_q  <= '0;
      res_q <= '0;
      exc_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rst_q <= 1'b0;
      if (grant_top) begin
        op_q <= op_top;
        a_q  <= a_top;
        b_q  <= b_top;
        rd_q <= rd_top;
      end else if (grant_bot) begin
        op_q <= op_bot;
        a_q  <= a_bot;
        b_q  <= b_bot;
        rd_q <= rd_bot;
      end
      if (state == MDS_WAIT) begin
        if (md_resultRDY) begin
          res_q <= md_result;
          exc_q <= md_exception;
        end else if (wd_expired) begin
          res_q <= '0;
          exc_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_issue_scheduler.sv
// tb_multdiv_issue_scheduler: random + directed bench with a transaction model.
// Define MD_WATCHDOG_EN to also exercise the timeout path (TIMEOUT=8).
module tb_multdiv_issue_scheduler;

  localparam int DW = 32;
  localparam int RW = 5;
`ifdef MD_WATCHDOG_EN
  localparam int TO = 8;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          req_top, op_top, req_bot, op_bot, flush;
  logic [DW-1:0] a_top, b_top, a_bot, b_bot;
  logic [RW-1:0] rd_top, rd_bot;
  logic          grant_top, grant_bot, md_ctrl_mult, md_ctrl_div;
  logic [DW-1:0] md_operandA, md_operandB, md_result, wb_data;
  logic          md_exception, md_resultRDY, wb_valid, wb_exception, busy;
  logic [RW-1:0] wb_rd, busy_rd;

  always #5 clock = ~clock;

  multdiv_issue_scheduler #(
    .DATA_W(DW),
    .RD_W(RW)
`ifdef MD_WATCHDOG_EN
    ,
    .TIMEOUT(TO)
`endif
  ) dut (
    .clock(clock), .reset(reset),
    .req_top(req_top), .op_top(op_top), .a_top(a_top),
    .b_top(b_top), .rd_top(rd_top),
    .req_bot(req_bot), .op_bot(op_bot), .a_bot(a_bot),
    .b_bot(b_bot), .rd_bot(rd_bot),
    .flush(flush),
    .grant_top(grant_top), .grant_bot(grant_bot),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_result(md_result), .md_exception(md_exception),
    .md_resultRDY(md_resultRDY),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_exception(wb_exception),
    .busy(busy), .busy_rd(busy_rd)
  );

  int vectors = 0;
  int miscompares = 0;

  // model: one in-flight transaction, counted in cycles since acceptance
  bit            m_in, m_got, m_after_rst, m_op, m_exc;
  int            m_cyc;
  logic [DW-1:0] m_a, m_b, m_res;
  logic [RW-1:0] m_rd;
  int            lat;
  bit            noise, force_rdy;

  logic          s_wb_valid, s_wb_exc, s_busy, s_gt, s_gb;
  logic [RW-1:0] s_wb_rd, s_busy_rd;
  logic [DW-1:0] s_wb_data;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void calc(input bit op, input logic [DW-1:0] a,
                               input logic [DW-1:0] b,
                               output logic [DW-1:0] r, output logic e);
    if (!op) begin
      r = a * b;
      e = 1'b0;
    end else if (b == 0) begin
      r = '1;
      e = 1'b1;
    end else begin
      r = a / b;
      e = 1'b0;
    end
  endfunction

  task automatic idle_inputs();
    reset = 0; flush = 0; force_rdy = 0;
    req_top = 0; op_top = 0; a_top = 0; b_top = 0; rd_top = 0;
    req_bot = 0; op_bot = 0; a_bot = 0; b_bot = 0; rd_bot = 0;
  endtask

  task automatic tick();
    bit waiting, gt, gb, live;
    int w;
    logic [DW-1:0] r;
    logic e;
    waiting = m_in && !m_got && m_cyc >= 2;
    w = m_cyc - 1;
    if (waiting && w >= lat) begin
      calc(m_op, m_a, m_b, r, e);
      md_resultRDY = 1; md_result = r; md_exception = e;
    end else begin
      md_resultRDY = !waiting && (force_rdy || (noise && $urandom_range(0, 3) == 0));
      md_result = $urandom;
      md_exception = 1'($urandom);
    end
    #1;
    live = !reset && !m_after_rst;
    gt = live && !m_in && !flush && req_top;
    gb = live && !m_in && !flush && req_bot && !req_top;
    chk("grant_top", grant_top, gt);
    chk("grant_bot", grant_bot, gb);
    chk("grant_excl", grant_top & grant_bot, 0);
    chk("start_mult", md_ctrl_mult, live && m_in && m_cyc == 1 && !m_op);
    chk("start_div", md_ctrl_div, live && m_in && m_cyc == 1 && m_op);
    if (live && m_in && !m_got) begin
      chk("operandA", md_operandA, m_a);
      chk("operandB", md_operandB, m_b);
    end
    chk("wb_valid", wb_valid, live && m_got);
    chk("wb_rd", wb_rd, (live && m_got) ? m_rd : '0);
    chk("wb_data", wb_data, (live && m_got) ? m_res : '0);
    chk("wb_exception", wb_exception, live && m_got && m_exc);
    chk("busy", busy, live && m_in);
    chk("busy_rd", busy_rd, (live && m_in) ? m_rd : '0);
    s_wb_valid = wb_valid; s_wb_rd = wb_rd; s_wb_data = wb_data;
    s_wb_exc = wb_exception; s_busy = busy; s_busy_rd = busy_rd;
    s_gt = grant_top; s_gb = grant_bot;
    @(posedge clock);
    if (reset) begin
      m_in = 0; m_got = 0; m_after_rst = 1;
    end else begin
      m_after_rst = 0;
      if (m_in && m_got) begin
        m_in = 0; m_got = 0;
      end else if (m_in) begin
        if (flush) m_in = 0;
        else if (m_cyc >= 2 && md_resultRDY) begin
          m_got = 1; m_res = md_result; m_exc = md_exception;
        end
`ifdef MD_WATCHDOG_EN
        else if (m_cyc >= 2 && w == TO) begin
          m_got = 1; m_res = '0; m_exc = 1;
        end
`endif
        m_cyc++;
      end else if (gt || gb) begin
        m_in = 1; m_cyc = 1;
        m_op = gt ? op_top : op_bot;
        m_a = gt ? a_top : a_bot;
        m_b = gt ? b_top : b_bot;
        m_rd = gt ? rd_top : rd_bot;
      end
    end
    @(negedge clock);
  endtask

  task automatic wait_wb(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = s_wb_valid;
    end
    chk("wb_seen", seen, 1'b1);
  endtask

  initial begin
    m_in = 0; m_got = 0; m_after_rst = 0; m_cyc = 0;
    m_op = 0; m_exc = 0; m_a = 0; m_b = 0; m_res = 0; m_rd = 0;
    lat = 1; noise = 0;
    md_result = 0; md_exception = 0; md_resultRDY = 0;
    idle_inputs();
    @(negedge clock);
    reset = 1; req_top = 1;
    tick(); tick();
    reset = 0;
    tick();
    chk("rst_busy", s_busy, 0);
    chk("rst_grant", s_gt, 0);
    req_top = 0;
    tick();

    // single mult 6*7 -> r3, ready 5 cycles after start
    lat = 5;
    req_top = 1; op_top = 0; a_top = 6; b_top = 7; rd_top = 3;
    tick();
    chk("mult_grant", s_gt, 1);
    req_top = 0;
    wait_wb(20);
    chk("mult_rd", s_wb_rd, 3);
    chk("mult_data", s_wb_data, 42);

    // dual request: top mult 3*5 r4, bot div 20/4 r5
    lat = 2;
    req_top = 1; op_top = 0; a_top = 3; b_top = 5; rd_top = 4;
    req_bot = 1; op_bot = 1; a_bot = 20; b_bot = 4; rd_bot = 5;
    tick();
    chk("dual_top", s_gt, 1);
    chk("dual_bot_stall", s_gb, 0);
    req_top = 0;
    wait_wb(20);
    chk("dual_rd_top", s_wb_rd, 4);
    chk("dual_data_top", s_wb_data, 15);
    tick();
    chk("dual_bot_grant", s_gb, 1);
    req_bot = 0;
    wait_wb(20);
    chk("dual_rd_bot", s_wb_rd, 5);
    chk("dual_data_bot", s_wb_data, 5);

    // divide by zero
    req_top = 1; op_top = 1; a_top = 9; b_top = 0; rd_top = 7;
    tick();
    req_top = 0;
    wait_wb(20);
    chk("dz_exc", s_wb_exc, 1);
    chk("dz_rd", s_wb_rd, 7);

    // flush in the second WAIT cycle, then stale ready
    lat = 4;
    req_top = 1; op_top = 0; a_top = 2; b_top = 2; rd_top = 8;
    tick();
    req_top = 0;
    tick(); tick();
    flush = 1;
    tick();
    flush = 0; force_rdy = 1;
    tick();
    chk("flush_busy", s_busy, 0);
    chk("flush_nowb", s_wb_valid, 0);
    tick();
    force_rdy = 0;
    req_top = 1; op_top = 0; a_top = 11; b_top = 13; rd_top = 9;
    tick();
    req_top = 0;
    wait_wb(20);
    chk("post_flush_data", s_wb_data, 143);

    // flush collides with ready in WAIT
    lat = 1;
    req_top = 1; op_top = 1; a_top = 100; b_top = 3; rd_top = 10;
    tick();
    req_top = 0;
    tick();
    flush = 1;
    tick();
    flush = 0;
    tick();
    chk("collide_nowb", s_wb_valid, 0);
    chk("collide_busy", s_busy, 0);

    // reset in the middle of WAIT
    lat = 6;
    req_top = 1; op_top = 0; a_top = 4; b_top = 4; rd_top = 12;
    tick();
    req_top = 0;
    tick(); tick();
    reset = 1;
    tick();
    reset = 0;
    tick();
    chk("rst_mid_busy", s_busy, 0);
    chk("rst_mid_busy_rd", s_busy_rd, 0);

`ifdef MD_WATCHDOG_EN
    // watchdog: unit never answers
    lat = 1000;
    req_top = 1; op_top = 1; a_top = 50; b_top = 5; rd_top = 14;
    tick();
    req_top = 0;
    wait_wb(30);
    chk("wd_exc", s_wb_exc, 1);
    chk("wd_data", s_wb_data, 0);
    chk("wd_rd", s_wb_rd, 14);
`endif

    // randomized traffic
    noise = 1;
    for (int c = 0; c < 2000; c++) begin
      if (!m_in) lat = $urandom_range(1, 6);
      reset = ($urandom_range(0, 99) < 2);
      flush = ($urandom_range(0, 99) < 8);
      req_top = ($urandom_range(0, 9) < 3);
      req_bot = ($urandom_range(0, 9) < 4);
      op_top = 1'($urandom); op_bot = 1'($urandom);
      a_top = $urandom; a_bot = $urandom_range(0, 5000);
      b_top = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 1000);
      b_bot = ($urandom_range(0, 7) == 0) ? 0 : $urandom;
      rd_top = RW'($urandom); rd_bot = RW'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
